// File: rtl/hs_flow_quantizer_if.sv
// Pixel stream interface of the flow quantizer: flow samples in, quantized
// pixels and per-frame statistics out. The driver side uses the master
// modport and the quantizer uses the slave modport.
interface hs_flow_quantizer_if #(
    parameter int FP_WIDTH  = 26,
    parameter int CNT_WIDTH = 18
);
    logic                 io_valid_in;
    logic                 io_frame_sync_in;
    logic [FP_WIDTH-1:0]  io_data_in_u;
    logic [FP_WIDTH-1:0]  io_data_in_v;
    logic [7:0]           io_threshold;

    logic                 io_valid_out;
    logic                 io_frame_sync_out;
    logic [7:0]           io_mag;
    logic [2:0]           io_dir;
    logic                 io_stat_valid;
    logic [7:0]           io_stat_max;
    logic [CNT_WIDTH-1:0] io_stat_count;

    modport master (
        output io_valid_in, io_frame_sync_in, io_data_in_u, io_data_in_v, io_threshold,
        input  io_valid_out, io_frame_sync_out, io_mag, io_dir,
        input  io_stat_valid, io_stat_max, io_stat_count
    );

    modport slave (
        input  io_valid_in, io_frame_sync_in, io_data_in_u, io_data_in_v, io_threshold,
        output io_valid_out, io_frame_sync_out, io_mag, io_dir,
        output io_stat_valid, io_stat_max, io_stat_count
    );
endinterface

// File: rtl/hs_flow_quantizer.sv
// Flow quantizer: turns the signed (u, v) optical-flow stream into an 8-bit
// saturated L1 magnitude plus a direction octant per pixel, and gathers
// per-frame peak magnitude and over-threshold pixel count.
// Stage 1 handles frame tracking and absolute values; stage 2 produces the
// magnitude, direction and statistics.
module hs_flow_quantizer #(
    parameter int FP_WIDTH     = 26,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 256,
    parameter int MAG_SHIFT    = 12,
    parameter int CNT_WIDTH    = 18
) (
    input  logic clk,
    input  logic reset,
    hs_flow_quantizer_if.slave bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FRAME_PIXELS = CNT_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);

    // ---------------- stage 0: acceptance decisions ----------------
    state_t               state;
    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [7:0]           thr_q;

    logic                 acc_first;
    logic                 acc_take;
    logic                 acc_last;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic [FP_WIDTH-1:0]  abs_u;
    logic [FP_WIDTH-1:0]  abs_v;

    // Classify the incoming pixel and form its magnitudes of u and v.
    always_comb begin
        acc_first = bus.io_valid_in & bus.io_frame_sync_in;
        acc_take  = acc_first | (bus.io_valid_in & (state == RUN));
        next_cnt  = acc_first ? CNT_WIDTH'(1) : pix_cnt + CNT_WIDTH'(1);
        acc_last  = acc_take & (next_cnt == FRAME_PIXELS);
        // The most negative input negates to itself, which read unsigned is 2^(FP_WIDTH-1).
        abs_u = bus.io_data_in_u[FP_WIDTH-1] ? (~bus.io_data_in_u + FP_WIDTH'(1)) : bus.io_data_in_u;
        abs_v = bus.io_data_in_v[FP_WIDTH-1] ? (~bus.io_data_in_v + FP_WIDTH'(1)) : bus.io_data_in_v;
    end

    // ---------------- stage 1 registers ----------------
    logic                s1_valid;
    logic                s1_first;
    logic                s1_last;
    logic                s1_u_neg;
    logic                s1_v_neg;
    logic [FP_WIDTH-1:0] s1_abs_u;
    logic [FP_WIDTH-1:0] s1_abs_v;
    logic [7:0]          s1_thr;

    // Frame FSM and first pipeline stage; the threshold travels with each pixel
    // so a back-to-back frame start cannot disturb the previous frame's count.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            thr_q    <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_u_neg <= 1'b0;
            s1_v_neg <= 1'b0;
            s1_abs_u <= '0;
            s1_abs_v <= '0;
            s1_thr   <= '0;
        end else begin
            s1_valid <= acc_take;
            s1_first <= acc_first;
            s1_last  <= acc_last;
            if (acc_first) begin
                thr_q <= bus.io_threshold;
            end
            if (acc_take) begin
                s1_u_neg <= bus.io_data_in_u[FP_WIDTH-1];
                s1_v_neg <= bus.io_data_in_v[FP_WIDTH-1];
                s1_abs_u <= abs_u;
                s1_abs_v <= abs_v;
                s1_thr   <= acc_first ? bus.io_threshold : thr_q;
                pix_cnt  <= acc_last ? '0 : next_cnt;
                state    <= acc_last ? IDLE : RUN;
            end
        end
    end

    // ---------------- stage 2: magnitude, direction, statistics ----------------
    logic [FP_WIDTH:0]    sum;
    logic [FP_WIDTH:0]    shr;
    logic [7:0]           mag_c;
    logic [2:0]           dir_c;
    logic                 u_ge_v;
    logic [7:0]           acc_max;
    logic [CNT_WIDTH-1:0] acc_cnt;
    logic [7:0]           acc_max_next;
    logic [CNT_WIDTH-1:0] acc_cnt_next;

    // Saturated L1 magnitude, octant, and the running frame statistics.
    always_comb begin
        sum    = {1'b0, s1_abs_u} + {1'b0, s1_abs_v};
        shr    = sum >> MAG_SHIFT;
        mag_c  = (shr > (FP_WIDTH+1)'(255)) ? 8'hFF : shr[7:0];
        u_ge_v = (s1_abs_u >= s1_abs_v);
        unique case ({s1_u_neg, s1_v_neg})
            2'b00:   dir_c = u_ge_v ? 3'd0 : 3'd1;
            2'b10:   dir_c = u_ge_v ? 3'd3 : 3'd2;
            2'b11:   dir_c = u_ge_v ? 3'd4 : 3'd5;
            default: dir_c = u_ge_v ? 3'd7 : 3'd6;
        endcase
        acc_max_next = (s1_first || (mag_c > acc_max)) ? mag_c : acc_max;
        acc_cnt_next = (s1_first ? '0 : acc_cnt) + CNT_WIDTH'(mag_c > s1_thr);
    end

    logic                 valid_q;
    logic                 sync_q;
    logic [7:0]           mag_q;
    logic [2:0]           dir_q;
    logic                 stat_valid_q;
    logic [7:0]           stat_max_q;
    logic [CNT_WIDTH-1:0] stat_count_q;

    // Output registers: pixel fields hold across gaps, statistics hold until
    // the final pixel of the next complete frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            sync_q       <= 1'b0;
            mag_q        <= '0;
            dir_q        <= '0;
            acc_max      <= '0;
            acc_cnt      <= '0;
            stat_valid_q <= 1'b0;
            stat_max_q   <= '0;
            stat_count_q <= '0;
        end else begin
            valid_q      <= s1_valid;
            sync_q       <= s1_valid & s1_first;
            stat_valid_q <= s1_valid & s1_last;
            if (s1_valid) begin
                mag_q   <= mag_c;
                dir_q   <= dir_c;
                acc_max <= acc_max_next;
                acc_cnt <= acc_cnt_next;
                if (s1_last) begin
                    stat_max_q   <= acc_max_next;
                    stat_count_q <= acc_cnt_next;
                end
            end
        end
    end

    assign bus.io_valid_out      = valid_q;
    assign bus.io_frame_sync_out = sync_q;
    assign bus.io_mag            = mag_q;
    assign bus.io_dir            = dir_q;
    assign bus.io_stat_valid     = stat_valid_q;
    assign bus.io_stat_max       = stat_max_q;
    assign bus.io_stat_count     = stat_count_q;

endmodule

// File: tb/tb_hs_flow_quantizer.sv
// Self-checking bench for hs_flow_quantizer on a small 8x4 frame: directed
// arithmetic corners, then randomized frames compared against a behavioural
// model that keeps each frame's magnitudes and summarizes them at frame end.
module tb_hs_flow_quantizer;

    localparam int FP_W   = 26;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int SHIFT  = 12;
    localparam int CNT_W  = 18;
    localparam int TOTAL  = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hs_flow_quantizer_if #(.FP_WIDTH(FP_W), .CNT_WIDTH(CNT_W)) bus ();

    hs_flow_quantizer #(
        .FP_WIDTH(FP_W), .IMAGE_WIDTH(IMG_W), .IMAGE_HEIGHT(IMG_H),
        .MAG_SHIFT(SHIFT), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]       mag;
        logic [2:0]       dir;
        logic             sync;
        logic             stat;
        logic [7:0]       smax;
        logic [CNT_W-1:0] scnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    longint     cyc = 0;
    longint     pulse_q[$];
    bit         in_frame = 1'b0;
    logic [7:0] frame_thr;
    int         frame_mags[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference arithmetic straight from the signed values.
    function automatic void ref_pix(input logic [FP_W-1:0] u, input logic [FP_W-1:0] v,
                                    output logic [7:0] m, output logic [2:0] d);
        longint su, sv, au, av, q;
        su = u[FP_W-1] ? longint'(u) - (longint'(1) << FP_W) : longint'(u);
        sv = v[FP_W-1] ? longint'(v) - (longint'(1) << FP_W) : longint'(v);
        au = (su < 0) ? -su : su;
        av = (sv < 0) ? -sv : sv;
        q  = (au + av) / (longint'(1) << SHIFT);
        m  = (q > 255) ? 8'd255 : 8'(q);
        if (su >= 0 && sv >= 0)     d = (au >= av) ? 3'd0 : 3'd1;
        else if (su < 0 && sv >= 0) d = (au >= av) ? 3'd3 : 3'd2;
        else if (su < 0 && sv < 0)  d = (au >= av) ? 3'd4 : 3'd5;
        else                        d = (au >= av) ? 3'd7 : 3'd6;
    endfunction

    // Frame model: collect the frame's magnitudes, summarize on the last one.
    task automatic model_pixel(input logic sync, input logic [FP_W-1:0] u,
                               input logic [FP_W-1:0] v, input logic [7:0] thr);
        exp_t e;
        int mx, cnt;
        ref_pix(u, v, e.mag, e.dir);
        if (sync) begin
            in_frame  = 1'b1;
            frame_thr = thr;
            frame_mags.delete();
        end else if (!in_frame) begin
            return;
        end
        frame_mags.push_back(int'(e.mag));
        e.sync = sync;
        e.stat = 1'b0;
        e.smax = '0;
        e.scnt = '0;
        if (frame_mags.size() == TOTAL) begin
            mx = 0;
            cnt = 0;
            foreach (frame_mags[i]) begin
                if (frame_mags[i] > mx) mx = frame_mags[i];
                if (frame_mags[i] > int'(frame_thr)) cnt++;
            end
            e.stat   = 1'b1;
            e.smax   = 8'(mx);
            e.scnt   = CNT_W'(cnt);
            in_frame = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [FP_W-1:0] rand_fp();
        int s;
        case ($urandom_range(0, 3))
            0: return FP_W'($urandom);
            1: begin s = int'($urandom_range(0, 1 << 21)) - (1 << 20); return FP_W'(s); end
            2: begin s = int'($urandom_range(0, 65535)) - 32768; return FP_W'(s); end
            default: return $urandom_range(0, 1) ? {1'b1, {(FP_W-1){1'b0}}} : {1'b0, {(FP_W-1){1'b1}}};
        endcase
    endfunction

    task automatic send(input logic sync, input logic [FP_W-1:0] u,
                        input logic [FP_W-1:0] v, input logic [7:0] thr);
        @(negedge clk);
        bus.io_valid_in      = 1'b1;
        bus.io_frame_sync_in = sync;
        bus.io_data_in_u     = u;
        bus.io_data_in_v     = v;
        bus.io_threshold     = thr;
        model_pixel(sync, u, v, thr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.io_valid_in      = 1'b0;
            bus.io_frame_sync_in = 1'($urandom);
            bus.io_data_in_u     = FP_W'($urandom);
            bus.io_data_in_v     = FP_W'($urandom);
            bus.io_threshold     = 8'($urandom);
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic random_frame(input bit gaps);
        logic [7:0] thr;
        thr = 8'($urandom);
        for (int k = 0; k < TOTAL; k++) begin
            send(k == 0, rand_fp(), rand_fp(), (k == 0) ? thr : 8'($urandom));
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic directed(input string tag, input logic [FP_W-1:0] u,
                            input logic [FP_W-1:0] v, input logic [7:0] m, input logic [2:0] d);
        send(1'b1, u, v, 8'd0);
        idle(1);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(bus.io_valid_out), 64'd1);
        check({tag, "_mag"}, 64'(bus.io_mag), 64'(m));
        check({tag, "_dir"}, 64'(bus.io_dir), 64'(d));
        check({tag, "_sync"}, 64'(bus.io_frame_sync_out), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_out"}, 64'(bus.io_valid_out), 64'd0);
        check({tag, "_sync_out"}, 64'(bus.io_frame_sync_out), 64'd0);
        check({tag, "_mag"}, 64'(bus.io_mag), 64'd0);
        check({tag, "_dir"}, 64'(bus.io_dir), 64'd0);
        check({tag, "_stat_valid"}, 64'(bus.io_stat_valid), 64'd0);
        check({tag, "_stat_max"}, 64'(bus.io_stat_max), 64'd0);
        check({tag, "_stat_count"}, 64'(bus.io_stat_count), 64'd0);
    endtask

    // Output monitor, sampling 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                if (bus.io_stat_valid === 1'b1) pulse_q.push_back(cyc);
                if (bus.io_valid_out === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("mag", 64'(bus.io_mag), 64'(e.mag));
                        check("dir", 64'(bus.io_dir), 64'(e.dir));
                        check("frame_sync_out", 64'(bus.io_frame_sync_out), 64'(e.sync));
                        check("stat_valid", 64'(bus.io_stat_valid), 64'(e.stat));
                        if (e.stat) begin
                            check("stat_max", 64'(bus.io_stat_max), 64'(e.smax));
                            check("stat_count", 64'(bus.io_stat_count), 64'(e.scnt));
                        end
                    end
                end else begin
                    check("idle_stat_valid", 64'(bus.io_stat_valid), 64'd0);
                    check("idle_sync_out", 64'(bus.io_frame_sync_out), 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int p0;
        reset                = 1'b0;
        bus.io_valid_in      = 1'b0;
        bus.io_frame_sync_in = 1'b0;
        bus.io_data_in_u     = '0;
        bus.io_data_in_v     = '0;
        bus.io_threshold     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Arithmetic corners, each as pixel 0 of a fresh frame.
        directed("basic", 26'h0004000, 26'h3FFE000, 8'd6, 3'd7);
        directed("sat_max", 26'h1FFFFFF, 26'h0000000, 8'd255, 3'd0);
        directed("min_val", 26'h2000000, 26'h0000000, 8'd255, 3'd3);
        directed("neg_pair", 26'h3FFF000, 26'h3FFF000, 8'd2, 3'd4);
        directed("zero", 26'h0000000, 26'h0000000, 8'd0, 3'd0);
        drain();

        // Magnitude ramp 0..31 with random gaps, threshold 5.
        p0 = pulse_q.size();
        for (int k = 0; k < TOTAL; k++) begin
            send(k == 0, FP_W'(k << SHIFT), '0, (k == 0) ? 8'd5 : 8'($urandom));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        drain();
        check("ramp_pulses", 64'(pulse_q.size() - p0), 64'd1);
        check("ramp_stat_max", 64'(bus.io_stat_max), 64'd31);
        check("ramp_stat_count", 64'(bus.io_stat_count), 64'd26);

        // Early resync: 10 pixels, then a fresh full frame.
        p0 = pulse_q.size();
        for (int k = 0; k < 10; k++) send(k == 0, rand_fp(), rand_fp(), 8'($urandom));
        random_frame(1'b1);
        drain();
        check("resync_pulses", 64'(pulse_q.size() - p0), 64'd1);

        // Asynchronous reset in the middle of a frame, away from the clock edge.
        random_frame(1'b0);
        drain();
        for (int k = 0; k < 6; k++) send(k == 0, rand_fp(), rand_fp(), 8'($urandom));
        idle(1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b0;
        exp_q.delete();
        in_frame = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) send(1'b0, rand_fp(), rand_fp(), 8'($urandom));
        drain();
        p0 = pulse_q.size();
        random_frame(1'b1);
        drain();
        check("post_reset_pulses", 64'(pulse_q.size() - p0), 64'd1);

        // Back-to-back frames with no bubbles.
        pulse_q.delete();
        random_frame(1'b0);
        random_frame(1'b0);
        drain();
        check("b2b_pulses", 64'(pulse_q.size()), 64'd2);
        if (pulse_q.size() == 2) begin
            check("b2b_spacing", 64'(pulse_q[1] - pulse_q[0]), 64'(TOTAL));
        end

        // A few more randomized frames, with and without gaps.
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
            random_frame(1'(f));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
